sram_capture_writer: RTL and testbench

Avalon-MM write master that sits directly upstream of the 4096×32 on-chip SRAM slave. It captures a programmed number of 32-bit words from an Avalon-ST sink into the SRAM, starting at a base word address. A small FIFO decouples the stream from an external arbiter's grant. Status (busy, done pulse, word count) goes to the control FSM or CSR block.

---
 rtl/sram_capture_writer.sv | 157 +++++++++++++++
 tb/tb_sram_capture_writer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_capture_writer.sv
// rtl/sram_capture_writer.sv - Avalon-ST to SRAM capture write master with skid FIFO.
// Optional running checksum of written words: define CAPTURE_CHECKSUM_EN.
module sram_capture_writer #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     words_written,
  output logic [DATA_W-1:0]   checksum,
  input  logic [DATA_W-1:0]   snk_data,
  input  logic                snk_valid,
  output logic                snk_ready,
  input  logic                sram_grant,
  output logic [ADDR_W-1:0]   sram_address,
  output logic [DATA_W/8-1:0] sram_byteenable,
  output logic                sram_chipselect,
  output logic                sram_write,
  output logic [DATA_W-1:0]   sram_writedata,
  output logic                sram_clken
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = FIFO_DEPTH[PTR_W:0];

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     acc_q, acc_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic [ADDR_W:0]     words_inc;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]      count_q;

  logic fifo_full, fifo_empty;
  logic start_acc, in_run, push, pop, flush;

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign in_run     = (state_q == S_RUN);
  assign start_acc  = (state_q == S_IDLE) & start & ~abort;

  assign snk_ready  = in_run & ~fifo_full & (acc_q < len_q);
  assign push       = snk_valid & snk_ready;
  // An abort cycle never commits a word to the SRAM.
  assign pop        = in_run & ~fifo_empty & sram_grant & ~abort;
  assign flush      = abort | start_acc;
  assign words_inc  = words_q + 1'b1;

  assign busy            = in_run;
  assign done            = (state_q == S_DONE) & ~abort;
  assign words_written   = words_q;
  assign sram_address    = addr_q;
  assign sram_write      = pop;
  assign sram_chipselect = pop;
  assign sram_writedata  = mem_q[rd_ptr_q];
  assign sram_byteenable = '1;
  assign sram_clken      = 1'b1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_acc) state_d = (length == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        if (abort)                             state_d = S_IDLE;
        else if (pop && (words_inc == len_q))  state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    len_d   = len_q;
    acc_d   = acc_q;
    words_d = words_q;
    if (start_acc) begin
      addr_d  = base_addr;
      len_d   = length;
      acc_d   = '0;
      words_d = '0;
    end else begin
      if (push) acc_d = acc_q + 1'b1;
      if (pop) begin
        addr_d  = addr_q + 1'b1;
        words_d = words_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      words_q <= words_d;
    end
  end

  // Skid FIFO; the head entry drives sram_writedata straight from storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= snk_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef CAPTURE_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       checksum_q <= '0;
    else if (start_acc) checksum_q <= '0;
    else if (pop)       checksum_q <= checksum_q + sram_writedata;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_sram_capture_writer.sv
// tb/tb_sram_capture_writer.sv - randomized self-checking bench for sram_capture_writer.
module tb_sram_capture_writer;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int BUDGET = 20000;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                start, abort;
  logic [ADDR_W-1:0]   base_addr;
  logic [ADDR_W:0]     length;
  logic                busy, done;
  logic [ADDR_W:0]     words_written;
  logic [DATA_W-1:0]   checksum;
  logic [DATA_W-1:0]   snk_data;
  logic                snk_valid, snk_ready;
  logic                sram_grant;
  logic [ADDR_W-1:0]   sram_address;
  logic [DATA_W/8-1:0] sram_byteenable;
  logic                sram_chipselect, sram_write;
  logic [DATA_W-1:0]   sram_writedata;
  logic                sram_clken;

  int checks = 0;
  int errors = 0;

  sram_capture_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length), .busy(busy), .done(done),
    .words_written(words_written), .checksum(checksum),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .sram_grant(sram_grant), .sram_address(sram_address),
    .sram_byteenable(sram_byteenable), .sram_chipselect(sram_chipselect),
    .sram_write(sram_write), .sram_writedata(sram_writedata), .sram_clken(sram_clken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_sum(input logic [DATA_W-1:0] s);
`ifdef CAPTURE_CHECKSUM_EN
    return s;
`else
    return '0;
`endif
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_words"}, words_written, 0);
    chk({tag, "_checksum"}, checksum, 0);
    chk({tag, "_ready"}, snk_ready, 0);
    chk({tag, "_write"}, sram_write, 0);
    chk({tag, "_cs"}, sram_chipselect, 0);
    chk({tag, "_addr"}, sram_address, 0);
    chk({tag, "_wdata"}, sram_writedata, 0);
    chk({tag, "_be"}, sram_byteenable, 4'hF);
    chk({tag, "_clken"}, sram_clken, 1);
  endtask

  // Reference: word i of the stream lands at (base + i) mod 4096; FIFO occupancy is
  // accepted-minus-written, acceptance stops at DEPTH occupancy or once length words are in.
  task automatic run_capture(input int base, input int len, input int p_valid, input int p_grant,
                             input int grant_off, input int abort_at, input bit seq);
    logic [DATA_W-1:0] words[$];
    logic [DATA_W-1:0] sum;
    int acc, wr, cyc;
    bit fin, ab, exp_ready, exp_write;
    sum = '0; acc = 0; wr = 0; cyc = 0; fin = 0;
    for (int i = 0; i < len; i++) words.push_back(seq ? DATA_W'(i + 1) : DATA_W'($urandom));

    @(negedge clk);
    start = 1; abort = 0; base_addr = ADDR_W'(base); length = (ADDR_W+1)'(len);
    snk_valid = 0; sram_grant = 1;
    #1 chk("start_busy_pre", busy, 0);
    @(negedge clk);
    start = 0;
    if (len == 0) begin
      #1;
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      chk("zero_write", sram_write, 0);
      chk("zero_words", words_written, 0);
      @(negedge clk);
      #1;
      chk("zero_done_clear", done, 0);
      chk("zero_busy_after", busy, 0);
      sram_grant = 0;
      return;
    end

    while (!fin && cyc < BUDGET) begin
      ab = (abort_at >= 0) && (wr == abort_at);
      abort = ab;
      snk_valid = ($urandom_range(99) < p_valid);
      snk_data = (acc < len) ? words[acc] : DATA_W'($urandom);
      sram_grant = (cyc >= grant_off) && ($urandom_range(99) < p_grant);
      start = !ab && ($urandom_range(99) < 5);
      base_addr = ADDR_W'($urandom);
      length = (ADDR_W+1)'($urandom);
      #1;
      exp_ready = ((acc - wr) < DEPTH) && (acc < len);
      exp_write = ((acc - wr) > 0) && sram_grant && !ab;
      chk("run_ready", snk_ready, exp_ready);
      chk("run_write", sram_write, exp_write);
      chk("run_cs", sram_chipselect, exp_write);
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("run_words", words_written, wr);
      chk("run_checksum", checksum, exp_sum(sum));
      if (grant_off > 0 && cyc == grant_off - 1) chk("stall_ready_low", snk_ready, 0);
      if (exp_write && sram_write) begin
        chk("write_addr", sram_address, (base + wr) % 4096);
        chk("write_data", sram_writedata, words[wr]);
      end
      if (snk_valid && exp_ready) acc++;
      if (exp_write) begin
        sum = sum + words[wr];
        wr++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (ab) begin
        abort = 0; start = 0; snk_valid = 0; sram_grant = 1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_words", words_written, wr);
        chk("abort_ready", snk_ready, 0);
        chk("abort_write", sram_write, 0);
        fin = 1;
      end else if (wr == len) begin
        start = 0; snk_valid = 0;
        #1;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_words", words_written, len);
        chk("done_checksum", checksum, exp_sum(sum));
        chk("done_write", sram_write, 0);
        @(negedge clk);
        #1;
        chk("done_clear", done, 0);
        chk("idle_busy", busy, 0);
        fin = 1;
      end
    end
    if (!fin) chk("capture_timeout", 0, 1);
    start = 0; abort = 0; snk_valid = 0; sram_grant = 0;
  endtask

  initial begin
    reset_n = 0; start = 0; abort = 0; base_addr = '0; length = '0;
    snk_data = '0; snk_valid = 0; sram_grant = 0;
    repeat (3) @(negedge clk);
    #1 check_reset_values("reset");
    reset_n = 1;

    run_capture(12'h010, 8, 100, 100, 0, -1, 1);
    run_capture(12'hFFE, 4, 100, 100, 0, -1, 0);
    run_capture(12'h100, 6, 100, 100, 10, -1, 0);
    run_capture(12'h200, 0, 100, 100, 0, -1, 0);
    run_capture(12'h300, 10, 100, 100, 0, 3, 0);
    run_capture(12'h300, 10, 100, 100, 0, -1, 0);

    for (int r = 0; r < 6; r++)
      run_capture($urandom_range(4095), $urandom_range(40, 1), $urandom_range(100, 40),
                  $urandom_range(100, 30), 0, (r == 2) ? 5 : -1, 0);

    run_capture($urandom_range(4095), 4096, 100, 100, 0, -1, 0);

    @(negedge clk);
    start = 1; abort = 1; base_addr = 12'h040; length = 13'd5;
    @(negedge clk);
    start = 0; abort = 0;
    #1;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_done", done, 0);
    chk("start_abort_ready", snk_ready, 0);
    @(negedge clk);
    #1 chk("start_abort_idle", busy, 0);

    @(negedge clk);
    start = 1; base_addr = 12'h555; length = 13'd10;
    @(negedge clk);
    start = 0; snk_valid = 1; sram_grant = 1; snk_data = 32'hDEAD_BEEF;
    repeat (4) @(negedge clk);
    #1 chk("pre_reset_busy", busy, 1);
    #1 reset_n = 0;
    #1 check_reset_values("midrun_reset");
    @(negedge clk);
    reset_n = 1; snk_valid = 0; sram_grant = 0;

    run_capture(12'h7F0, 12, 80, 70, 0, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
